// File: rtl/cfg_write_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cfg_regs_pkg
// Description : Register-bank constants shared by the SPI peripheral and the
//               configuration write scheduler: request address width, highest
//               implemented address, register addresses and scheduler states.
// Revision    : 1.0 - initial release
// ============================================================================
package cfg_regs_pkg;

    localparam int ADDR_W   = 7;
    localparam int MAX_ADDR = 4;
    localparam int N_REGS   = MAX_ADDR + 1;

    localparam logic [ADDR_W-1:0] REG_0X00 = 7'd0;
    localparam logic [ADDR_W-1:0] REG_0X01 = 7'd1;
    localparam logic [ADDR_W-1:0] REG_0X02 = 7'd2;
    localparam logic [ADDR_W-1:0] REG_0X03 = 7'd3;
    localparam logic [ADDR_W-1:0] REG_0X04 = 7'd4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/cfg_write_scheduler_if.sv
`default_nettype none
// ============================================================================
// Interface   : cfg_wr_if
// Description : Multi-requester register write bus.
//               req_valid/req_addr/req_data : requester -> scheduler (flattened,
//               requester i at [i*ADDR_W +: ADDR_W] and [i*W +: W])
//               req_ready (one-hot) / req_err : scheduler -> requesters
// Revision    : 1.0 - initial release
// ============================================================================
interface cfg_wr_if #(
    parameter int N_REQ  = 2,
    parameter int W      = 8,
    parameter int ADDR_W = cfg_regs_pkg::ADDR_W
) ();
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*W-1:0]      req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    req_err;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, req_err
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, req_err
    );
endinterface
`default_nettype wire

// File: rtl/cfg_write_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. The first asserted request
//               after index 'last' (wrapping) receives the one-hot grant.
//               req  in  N   request vector
//               last in  LW  index of the previous winner
//               gnt  out N   one-hot grant (all zero when no request)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]                        req,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] last,
    output logic [N-1:0]                        gnt
);
    localparam int LW = (N > 1) ? $clog2(N) : 1;

    logic [LW-1:0] w_idx;
    logic          w_found;

    // Scan from last+1 around the ring; the first requester seen wins.
    always_comb begin
        gnt     = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            w_idx = LW'((int'(last) + k) % N);
            if (!w_found && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/cfg_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : cfg_write_scheduler
// Description : Round-robin write scheduler for the configuration register
//               bank. Accepted writes land in staging registers; staging is
//               copied to the active outputs on commit_i (or every cycle when
//               IMMEDIATE=1) so downstream logic sees glitch-free updates.
//               clk, rst_n (sync, active-low)
//               bus       slave side of cfg_wr_if (valid/addr/data, ready/err)
//               commit_i  copy staging to active when pending
//               pending   staging holds uncommitted writes
//               reg_0x00..reg_0x04  active register values
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_write_scheduler #(
    parameter int W         = 8,
    parameter int ADDR_W    = cfg_regs_pkg::ADDR_W,
    parameter int N_REQ     = 2,
    parameter int MAX_ADDR  = cfg_regs_pkg::MAX_ADDR,
    parameter int IMMEDIATE = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    cfg_wr_if.slave      bus,
    input  logic         commit_i,
    output logic         pending,
    output logic [W-1:0] reg_0x00,
    output logic [W-1:0] reg_0x01,
    output logic [W-1:0] reg_0x02,
    output logic [W-1:0] reg_0x03,
    output logic [W-1:0] reg_0x04
);
    import cfg_regs_pkg::*;

    localparam int             LW         = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [LW-1:0]  C_LAST_RST = LW'(N_REQ - 1);

    sched_state_t         r_state;
    logic [LW-1:0]        r_winner;
    logic [LW-1:0]        r_last;
    logic [ADDR_W-1:0]    r_addr;
    logic [W-1:0]         r_data;
    logic [N_REQ-1:0]     r_ready;
    logic                 r_err;
    logic                 r_pending;
    logic [W-1:0]         r_stage  [N_REGS];
    logic [W-1:0]         r_active [N_REGS];

    logic [N_REQ-1:0]     w_gnt;
    logic [LW-1:0]        w_gnt_idx;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [W-1:0]         w_sel_data;
    logic                 w_sel_bad;
    logic                 w_wr;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req  (bus.req_valid),
        .last (r_last),
        .gnt  (w_gnt)
    );

    // Winner index and its payload, selected by the one-hot grant.
    always_comb begin
        w_gnt_idx  = '0;
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) begin
                w_gnt_idx  = LW'(i);
                w_sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
                w_sel_data = bus.req_data[i*W +: W];
            end
        end
    end

    assign w_sel_bad = (w_sel_addr > ADDR_W'(MAX_ADDR));
    // r_err is registered together with the latched payload, so it also
    // marks the GRANT cycle's write as out of range.
    assign w_wr      = (r_state == GRANT) && !r_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_winner  <= '0;
            r_last    <= C_LAST_RST;
            r_addr    <= '0;
            r_data    <= '0;
            r_ready   <= '0;
            r_err     <= 1'b0;
            r_pending <= 1'b0;
            for (int k = 0; k < N_REGS; k++) begin
                r_stage[k]  <= '0;
                r_active[k] <= '0;
            end
        end else begin
            r_ready <= '0;
            r_err   <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (|bus.req_valid) begin
                        r_winner <= w_gnt_idx;
                        r_addr   <= w_sel_addr;
                        r_data   <= w_sel_data;
                        r_ready  <= w_gnt;
                        r_err    <= w_sel_bad;
                        r_state  <= GRANT;
                    end
                end
                GRANT: begin
                    r_last  <= r_winner;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase

            // Commit samples staging before this cycle's write lands, so a
            // write in the commit cycle stays pending for the next commit.
            if (IMMEDIATE != 0) begin
                for (int k = 0; k < N_REGS; k++) r_active[k] <= r_stage[k];
                r_pending <= 1'b0;
            end else if (commit_i && r_pending) begin
                for (int k = 0; k < N_REGS; k++) r_active[k] <= r_stage[k];
                r_pending <= 1'b0;
            end

            if (w_wr) begin
                for (int k = 0; k < N_REGS; k++) begin
                    if (r_addr == ADDR_W'(k)) r_stage[k] <= r_data;
                end
                if (IMMEDIATE == 0) r_pending <= 1'b1;
            end
        end
    end

    // Masking with rst_n suppresses the accept pulse when reset hits the
    // GRANT cycle, so no requester sees a write that never happened.
    assign bus.req_ready = r_ready & {N_REQ{rst_n}};
    assign bus.req_err   = r_err & rst_n;
    assign pending       = r_pending;

    assign reg_0x00 = r_active[0];
    assign reg_0x01 = r_active[1];
    assign reg_0x02 = r_active[2];
    assign reg_0x03 = r_active[3];
    assign reg_0x04 = r_active[4];
endmodule
`default_nettype wire

// File: tb/tb_cfg_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_cfg_write_scheduler
// Description : Self-checking bench for cfg_write_scheduler. Drives a deferred
//               commit instance and an IMMEDIATE instance with the same
//               request stream and compares both against a transaction-level
//               register-bank model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cfg_write_scheduler;

    localparam int C_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  valid;
    logic [13:0] addr;
    logic [15:0] data;
    logic        commit;

    always #5 clk = ~clk;

    cfg_wr_if #(.N_REQ(2), .W(8), .ADDR_W(7)) bus_d ();
    cfg_wr_if #(.N_REQ(2), .W(8), .ADDR_W(7)) bus_i ();

    assign bus_d.req_valid = valid;
    assign bus_d.req_addr  = addr;
    assign bus_d.req_data  = data;
    assign bus_i.req_valid = valid;
    assign bus_i.req_addr  = addr;
    assign bus_i.req_data  = data;

    logic            pend_d, pend_i;
    logic [4:0][7:0] rd, ri;

    cfg_write_scheduler #(.W(8), .ADDR_W(7), .N_REQ(2), .MAX_ADDR(4), .IMMEDIATE(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus_d), .commit_i(commit), .pending(pend_d),
        .reg_0x00(rd[0]), .reg_0x01(rd[1]), .reg_0x02(rd[2]), .reg_0x03(rd[3]), .reg_0x04(rd[4])
    );

    cfg_write_scheduler #(.W(8), .ADDR_W(7), .N_REQ(2), .MAX_ADDR(4), .IMMEDIATE(1)) u_imm (
        .clk(clk), .rst_n(rst_n), .bus(bus_i), .commit_i(commit), .pending(pend_i),
        .reg_0x00(ri[0]), .reg_0x01(ri[1]), .reg_0x02(ri[2]), .reg_0x03(ri[3]), .reg_0x04(ri[4])
    );

    // Reference model: staging/active banks, pending flag, last winner.
    int m_stage  [5];
    int m_active [5];
    bit m_pend;
    int m_last;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 5; k++) begin
            m_stage[k]  = 0;
            m_active[k] = 0;
        end
        m_pend = 1'b0;
        m_last = 1;
    endtask

    function automatic int rr_pick(input logic [1:0] v);
        for (int k = 1; k <= 2; k++) begin
            if (v[(m_last + k) % 2]) return (m_last + k) % 2;
        end
        return -1;
    endfunction

    task automatic check_bank(input string tag);
        for (int k = 0; k < 5; k++)
            check($sformatf("%s_reg%0d", tag, k), {24'd0, rd[k]}, m_active[k]);
        check({tag, "_pending"}, {31'd0, pend_d}, {31'd0, m_pend});
    endtask

    task automatic set_req(input int p, input int a, input int d);
        valid[p]        = 1'b1;
        addr[p*7 +: 7]  = a[6:0];
        data[p*8 +: 8]  = d[7:0];
    endtask

    task automatic do_reset(input string tag);
        rst_n  = 1'b0;
        valid  = '0;
        addr   = '0;
        data   = '0;
        commit = 1'b0;
        tick();
        tick();
        model_reset();
        check({tag, "_ready"}, {30'd0, bus_d.req_ready}, 32'd0);
        check({tag, "_err"}, {31'd0, bus_d.req_err}, 32'd0);
        check_bank(tag);
        rst_n = 1'b1;
    endtask

    // Grants up to n requests from the currently asserted valids. Each grant
    // is expected exactly one cycle after the DUT samples the request.
    task automatic serve(input string tag, input int n, input bit hold, input bit cig);
        for (int g = 0; g < n; g++) begin
            int         w;
            logic [6:0] aw;
            logic [7:0] dw;
            if (valid == 2'b00) break;
            w  = rr_pick(valid);
            aw = addr[w*7 +: 7];
            dw = data[w*8 +: 8];
            tick();
            for (int k = 0; k < 5; k++)
                check($sformatf("%s_imm_reg%0d", tag, k), {24'd0, ri[k]}, m_stage[k]);
            check({tag, "_imm_pending"}, {31'd0, pend_i}, 32'd0);
            check({tag, "_ready"}, {30'd0, bus_d.req_ready}, 32'd1 << w);
            check({tag, "_err"}, {31'd0, bus_d.req_err}, {31'd0, (aw > C_MAX)});
            if (cig) commit = 1'b1;
            if (!hold) valid[w] = 1'b0;
            tick();
            commit = 1'b0;
            if (cig && m_pend) begin
                for (int k = 0; k < 5; k++) m_active[k] = m_stage[k];
                m_pend = 1'b0;
            end
            if (aw <= C_MAX) begin
                m_stage[aw] = dw;
                m_pend      = 1'b1;
            end
            m_last = w;
            check({tag, "_ready_gap"}, {30'd0, bus_d.req_ready}, 32'd0);
            check_bank(tag);
        end
    endtask

    task automatic do_commit(input string tag);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        if (m_pend) begin
            for (int k = 0; k < 5; k++) m_active[k] = m_stage[k];
            m_pend = 1'b0;
        end
        check_bank(tag);
    endtask

    initial begin
        valid  = '0;
        addr   = '0;
        data   = '0;
        commit = 1'b0;
        rst_n  = 1'b0;
        model_reset();

        // Single write, staged but not yet active, then committed.
        do_reset("rst0");
        set_req(0, 2, 8'h5A);
        serve("t1_wr", 1, 1'b0, 1'b0);
        check("t1_reg2_uncommitted", {24'd0, rd[2]}, 32'd0);
        do_commit("t1_commit");
        check("t1_reg2_committed", {24'd0, rd[2]}, 32'h5A);

        // Both ports continuously valid: grants alternate 0,1,0,1.
        do_reset("rst1");
        set_req(0, 0, 8'h11);
        set_req(1, 1, 8'h22);
        serve("t2_alt", 4, 1'b1, 1'b0);
        valid = '0;
        do_commit("t2_commit");
        check("t2_reg0", {24'd0, rd[0]}, 32'h11);
        check("t2_reg1", {24'd0, rd[1]}, 32'h22);

        // Out-of-range address: err pulse, nothing staged.
        set_req(1, 5, 8'hFF);
        serve("t3_bad", 1, 1'b0, 1'b0);
        do_commit("t3_commit");

        // Commit in the GRANT cycle copies only the pre-write staging.
        set_req(0, 3, 8'h44);
        serve("t4_pre", 1, 1'b0, 1'b0);
        set_req(0, 4, 8'h80);
        serve("t4_cig", 1, 1'b0, 1'b1);
        check("t4_reg3_copied", {24'd0, rd[3]}, 32'h44);
        check("t4_reg4_held", {24'd0, rd[4]}, 32'h00);
        do_commit("t4_commit");
        check("t4_reg4_final", {24'd0, rd[4]}, 32'h80);

        // Reset during GRANT: no accept, everything cleared, port0 next.
        set_req(0, 1, 8'h01);
        serve("t5_pre", 1, 1'b0, 1'b0);
        set_req(1, 3, 8'h33);
        tick();
        rst_n = 1'b0;
        #1;
        check("t5_ready_in_rst", {30'd0, bus_d.req_ready}, 32'd0);
        check("t5_err_in_rst", {31'd0, bus_d.req_err}, 32'd0);
        valid = '0;
        tick();
        model_reset();
        check_bank("t5_rst");
        check("t5_imm_reg3", {24'd0, ri[3]}, 32'd0);
        rst_n = 1'b1;
        set_req(0, 2, 8'h12);
        set_req(1, 3, 8'h34);
        serve("t5_after", 2, 1'b0, 1'b0);

        // IMMEDIATE instance: active follows staging one cycle later.
        do_reset("rst6");
        set_req(0, 0, 8'hA5);
        serve("t6_wr", 1, 1'b0, 1'b0);
        check("t6_imm_n2", {24'd0, ri[0]}, 32'h00);
        tick();
        check("t6_imm_n3", {24'd0, ri[0]}, 32'hA5);
        check("t6_imm_pending", {31'd0, pend_i}, 32'd0);
        check("t6_dut_uncommitted", {24'd0, rd[0]}, 32'h00);

        // Randomized mix of writes, collisions, commits and commit-in-grant.
        for (int it = 0; it < 40; it++) begin
            int op;
            op = int'($urandom_range(0, 3));
            case (op)
                0: do_commit($sformatf("rnd%0d_commit", it));
                1: begin
                    set_req(int'($urandom_range(0, 1)), int'($urandom_range(0, 6)),
                            int'($urandom_range(0, 255)));
                    serve($sformatf("rnd%0d_single", it), 1, 1'b0, 1'b0);
                end
                2: begin
                    set_req(0, int'($urandom_range(0, 6)), int'($urandom_range(0, 255)));
                    set_req(1, int'($urandom_range(0, 6)), int'($urandom_range(0, 255)));
                    serve($sformatf("rnd%0d_both", it), 2, 1'b0, 1'b0);
                end
                default: begin
                    set_req(int'($urandom_range(0, 1)), int'($urandom_range(0, 6)),
                            int'($urandom_range(0, 255)));
                    serve($sformatf("rnd%0d_cig", it), 1, 1'b0, 1'b1);
                end
            endcase
        end
        do_commit("final_commit");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
